// File: rtl/refresh_control_pkg.sv
// Shared DDR definitions for the refresh engine.
// Holds the FSM state enum, the DFI command encodings and the sizing
// constants that the refresh controller, its timer and the DFI interface use.
package refresh_control_pkg;

  // Maximum number of postponed refreshes, range 1..15.
  localparam int MAX_POSTPONE_DEFAULT = 8;
  // DFI phases per controller clock.
  localparam int NUM_PHASES = 4;
  // Width of the pending-refresh counter, large enough for 15.
  localparam int PEND_W = 4;
  localparam int ADDR_W = 14;
  localparam int BANK_W = 3;

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_IDLE,
    ST_REQ,
    ST_PREA,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC
  } state_e;

  // Command encoding as {cs_n, ras_n, cas_n, we_n}.
  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } dfi_cmd_t;

  localparam dfi_cmd_t CMD_DES = 4'b1111;  // deselect, used only while in reset
  localparam dfi_cmd_t CMD_NOP = 4'b0111;
  localparam dfi_cmd_t CMD_PRE = 4'b0010;
  localparam dfi_cmd_t CMD_REF = 4'b0001;

endpackage

// File: rtl/config_if.sv
// Timing configuration bundle.
//   trefi : refresh interval, core_clk cycles
//   trp   : precharge-to-refresh time, core_clk cycles
//   trfc  : refresh cycle time, core_clk cycles
interface config_if #(
  parameter int CNT_W = 16
) ();
  logic [CNT_W-1:0] trefi;
  logic [CNT_W-1:0] trp;
  logic [CNT_W-1:0] trfc;

  modport master (output trefi, output trp, output trfc);
  modport slave  (input trefi, input trp, input trfc);
endinterface

// File: rtl/dfi_if.sv
// DFI command-phase bundle toward the DFI mux.
//   cs_n/ras_n/cas_n/we_n : one bit per phase
//   cke                   : clock enable
//   address/bank          : one word per phase
interface dfi_if
  import refresh_control_pkg::*;
();
  logic [NUM_PHASES-1:0]             cs_n;
  logic [NUM_PHASES-1:0]             ras_n;
  logic [NUM_PHASES-1:0]             cas_n;
  logic [NUM_PHASES-1:0]             we_n;
  logic                              cke;
  logic [NUM_PHASES-1:0][ADDR_W-1:0] address;
  logic [NUM_PHASES-1:0][BANK_W-1:0] bank;

  modport master (output cs_n, output ras_n, output cas_n, output we_n,
                  output cke, output address, output bank);
  modport slave  (input cs_n, input ras_n, input cas_n, input we_n,
                  input cke, input address, input bank);
endinterface

// File: rtl/refresh_timer.sv
// tREFI interval counter and pending-refresh counter.
//   core_clk, core_arstn : clock, asynchronous active-low reset
//   en                   : engine enabled; low clears both counters
//   trefi                : refresh interval in cycles
//   ref_issue            : a REFRESH is on the bus this cycle
//   tick                 : interval counter has reached trefi this cycle
//   pending              : number of refreshes owed
//   urgent               : pending is saturated at MAX_POSTPONE
module refresh_timer
  import refresh_control_pkg::*;
#(
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic              core_clk,
  input  logic              core_arstn,
  input  logic              en,
  input  logic [CNT_W-1:0]  trefi,
  input  logic              ref_issue,
  output logic              tick,
  output logic [PEND_W-1:0] pending,
  output logic              urgent
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              urgent_q;

  // The counter runs 1..trefi; '>=' keeps it from running away if trefi
  // is lowered below the current count.
  assign tick = en && (cnt_q != '0) && (cnt_q >= trefi);

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (!en) begin
      cnt_d     = '0;
      pending_d = '0;
    end else begin
      cnt_d = tick ? CNT_W'(1) : cnt_q + CNT_W'(1);
      // A tick and a REF in the same cycle cancel. A tick at saturation is lost.
      if (tick && !ref_issue && (pending_q != PEND_MAX)) begin
        pending_d = pending_q + PEND_W'(1);
      end else if (ref_issue && !tick && (pending_q != '0)) begin
        pending_d = pending_q - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      cnt_q     <= '0;
      pending_q <= '0;
      urgent_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      urgent_q  <= (pending_d == PEND_MAX);
    end
  end

  assign pending = pending_q;
  assign urgent  = urgent_q;

endmodule

// File: rtl/refresh_control.sv
// Auto-refresh engine: requests the DFI bus from the scheduler, then issues
// PRECHARGE-ALL, waits tRP, issues REFRESH and waits tRFC, once per owed refresh.
//   core_clk, core_arstn : clock, asynchronous active-low reset (deassertion is
//                          expected to be aligned to core_clk by the reset source)
//   ddr_init_done        : enables the engine; low forces DISABLED
//   s_cfg                : tREFI / tRP / tRFC in core_clk cycles
//   ref_req / ref_gnt    : bus ownership handshake with the scheduler
//   ref_urgent           : postponement limit reached
//   ref_busy             : engine owns the DFI bus (PREA through WAIT_RFC)
//   ref_dfi              : registered command-phase outputs
module refresh_control
  import refresh_control_pkg::*;
#(
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic     core_clk,
  input  logic     core_arstn,
  input  logic     ddr_init_done,
  config_if.slave  s_cfg,
  output logic     ref_req,
  output logic     ref_urgent,
  input  logic     ref_gnt,
  output logic     ref_busy,
  dfi_if.master    ref_dfi
);

  logic              tick;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  trp_eff, trfc_eff;

  state_e            state_q;
  logic              ref_req_q, ref_busy_q, cke_q, a10_q;
  dfi_cmd_t          cmd0_q;   // phase 0 carries every real command
  dfi_cmd_t          cmd_hi_q; // phases 1..N-1 are always NOP once out of reset
  logic [CNT_W-1:0]  wait_q;   // cycles spent since PREA or since REF

  refresh_timer #(
    .MAX_POSTPONE (MAX_POSTPONE),
    .CNT_W        (CNT_W)
  ) u_timer (
    .core_clk   (core_clk),
    .core_arstn (core_arstn),
    .en         (ddr_init_done),
    .trefi      (s_cfg.trefi),
    .ref_issue  (state_q == ST_REF),
    .tick       (tick),
    .pending    (pending),
    .urgent     (ref_urgent)
  );

  assign trp_eff  = (s_cfg.trp  == '0) ? CNT_W'(1) : s_cfg.trp;
  assign trfc_eff = (s_cfg.trfc == '0) ? CNT_W'(1) : s_cfg.trfc;

  // Both waits count the command cycle itself, so tRP=5 puts REF five
  // cycles after PREA and tRFC=20 drops busy twenty cycles after REF.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q    <= ST_DISABLED;
      ref_req_q  <= 1'b0;
      ref_busy_q <= 1'b0;
      cke_q      <= 1'b0;
      a10_q      <= 1'b0;
      cmd0_q     <= CMD_DES;
      cmd_hi_q   <= CMD_DES;
      wait_q     <= '0;
    end else begin
      cke_q    <= ddr_init_done;
      cmd0_q   <= CMD_NOP;
      cmd_hi_q <= CMD_NOP;
      a10_q    <= 1'b0;
      if (!ddr_init_done) begin
        state_q    <= ST_DISABLED;
        ref_req_q  <= 1'b0;
        ref_busy_q <= 1'b0;
        wait_q     <= '0;
      end else begin
        case (state_q)
          ST_DISABLED: state_q <= ST_IDLE;
          ST_IDLE: begin
            // The tick term lets the request leave in the same update that
            // the first pending refresh is counted.
            if ((pending != '0) || tick) begin
              state_q   <= ST_REQ;
              ref_req_q <= 1'b1;
            end
          end
          ST_REQ: begin
            if (ref_gnt) begin
              state_q    <= ST_PREA;
              ref_req_q  <= 1'b0;
              ref_busy_q <= 1'b1;
              cmd0_q     <= CMD_PRE;
              a10_q      <= 1'b1;
              wait_q     <= CNT_W'(1);
            end
          end
          ST_PREA, ST_WAIT_RP: begin
            if (wait_q >= trp_eff) begin
              state_q <= ST_REF;
              cmd0_q  <= CMD_REF;
              wait_q  <= CNT_W'(1);
            end else begin
              state_q <= ST_WAIT_RP;
              wait_q  <= wait_q + CNT_W'(1);
            end
          end
          ST_REF, ST_WAIT_RFC: begin
            if (wait_q >= trfc_eff) begin
              state_q    <= ST_IDLE;
              ref_busy_q <= 1'b0;
              wait_q     <= '0;
            end else begin
              state_q <= ST_WAIT_RFC;
              wait_q  <= wait_q + CNT_W'(1);
            end
          end
          default: state_q <= ST_DISABLED;
        endcase
      end
    end
  end

  assign ref_req     = ref_req_q;
  assign ref_busy    = ref_busy_q;
  assign ref_dfi.cke = cke_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
      if (gi == 0) begin : g_p0
        assign ref_dfi.cs_n[gi]    = cmd0_q.cs_n;
        assign ref_dfi.ras_n[gi]   = cmd0_q.ras_n;
        assign ref_dfi.cas_n[gi]   = cmd0_q.cas_n;
        assign ref_dfi.we_n[gi]    = cmd0_q.we_n;
        // A10 high selects all banks for the precharge.
        assign ref_dfi.address[gi] = {{(ADDR_W-11){1'b0}}, a10_q, 10'b0};
      end else begin : g_pn
        assign ref_dfi.cs_n[gi]    = cmd_hi_q.cs_n;
        assign ref_dfi.ras_n[gi]   = cmd_hi_q.ras_n;
        assign ref_dfi.cas_n[gi]   = cmd_hi_q.cas_n;
        assign ref_dfi.we_n[gi]    = cmd_hi_q.we_n;
        assign ref_dfi.address[gi] = '0;
      end
      assign ref_dfi.bank[gi] = '0;
    end
  endgenerate

endmodule

// File: tb/tb_refresh_control.sv
// Directed bench for refresh_control: tREFI=100, tRP=5, tRFC=20 baseline,
// cycle n is the n-th rising edge after reset release; outputs sampled 1 time
// unit after each edge.
module tb_refresh_control;
  import refresh_control_pkg::*;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic ddr_init_done = 1'b1;
  logic ref_gnt = 1'b0;
  logic ref_req, ref_urgent, ref_busy;

  config_if #(.CNT_W(16)) cfg ();
  dfi_if dfi ();

  refresh_control #(.MAX_POSTPONE(8), .CNT_W(16)) dut (
    .core_clk      (clk),
    .core_arstn    (arstn),
    .ddr_init_done (ddr_init_done),
    .s_cfg         (cfg),
    .ref_req       (ref_req),
    .ref_urgent    (ref_urgent),
    .ref_gnt       (ref_gnt),
    .ref_busy      (ref_busy),
    .ref_dfi       (dfi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_pre = 0;
  int n_ref = 0;
  int snap_pre, snap_ref;

  always @(posedge clk or negedge arstn)
    if (!arstn) cyc <= 0;
    else        cyc <= cyc + 1;

  logic [3:0]  cmd0;
  logic [11:0] cmd_rest;
  assign cmd0     = {dfi.cs_n[0], dfi.ras_n[0], dfi.cas_n[0], dfi.we_n[0]};
  assign cmd_rest = {dfi.cs_n[3:1], dfi.ras_n[3:1], dfi.cas_n[3:1], dfi.we_n[3:1]};

  always @(negedge clk) begin
    if (cmd0 == 4'b0010) n_pre <= n_pre + 1;
    if (cmd0 == 4'b0001) n_ref <= n_ref + 1;
  end

  localparam logic [11:0] REST_NOP = 12'b000_111_111_111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < n) check("wait_timeout", 32'(cyc), 32'(n));
  endtask

  initial begin
    cfg.trefi = 16'd100;
    cfg.trp   = 16'd5;
    cfg.trfc  = 16'd20;

    // Reset values while core_arstn is low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",    32'(ref_req), 32'd0);
    check("rst_urgent", 32'(ref_urgent), 32'd0);
    check("rst_busy",   32'(ref_busy), 32'd0);
    check("rst_cmd",    32'({cmd0, cmd_rest}), 32'hFFFF);
    check("rst_cke",    32'(dfi.cke), 32'd0);
    check("rst_addr",   32'(dfi.address == '0 && dfi.bank == '0), 32'd1);
    check("rst_cnt",    32'(dut.u_timer.cnt_q), 32'd0);
    @(negedge clk);
    arstn = 1'b1;

    // First request lands at cycle 101.
    wait_cyc(100);
    check("req_c100", 32'(ref_req), 32'd0);
    check("cke_on",   32'(dfi.cke), 32'd1);
    wait_cyc(101);
    check("req_c101", 32'(ref_req), 32'd1);
    check("pend_c101", 32'(dut.pending), 32'd1);
    ref_gnt = 1'b1;

    // Grant sampled at 102 -> PREA at 102, REF at 107, busy low at 127.
    wait_cyc(102);
    ref_gnt = 1'b0;
    check("prea_cmd",  32'(cmd0), 32'b0010);
    check("prea_a10",  32'(dfi.address[0][10]), 32'd1);
    check("prea_rest", 32'(cmd_rest), 32'(REST_NOP));
    check("prea_req",  32'(ref_req), 32'd0);
    check("prea_busy", 32'(ref_busy), 32'd1);
    wait_cyc(103);
    check("wrp_nop",   32'(cmd0), 32'b0111);
    wait_cyc(106);
    check("wrp_state", 32'(dut.state_q), 32'(ST_WAIT_RP));
    wait_cyc(107);
    check("ref_cmd",   32'(cmd0), 32'b0001);
    check("ref_a10",   32'(dfi.address[0][10]), 32'd0);
    check("ref_rest",  32'(cmd_rest), 32'(REST_NOP));
    wait_cyc(108);
    check("pend_dec",  32'(dut.pending), 32'd0);
    wait_cyc(126);
    check("busy_c126", 32'(ref_busy), 32'd1);
    wait_cyc(127);
    check("busy_c127", 32'(ref_busy), 32'd0);

    // Withhold grant: ticks at 201..901 saturate pending at 8.
    wait_cyc(201);
    check("req_c201",  32'(ref_req), 32'd1);
    wait_cyc(900);
    check("pend_7",    32'(dut.pending), 32'd7);
    check("urg_lo",    32'(ref_urgent), 32'd0);
    wait_cyc(901);
    check("pend_8",    32'(dut.pending), 32'd8);
    check("urg_hi",    32'(ref_urgent), 32'd1);
    wait_cyc(1001);
    check("pend_sat",  32'(dut.pending), 32'd8);
    check("urg_sat",   32'(ref_urgent), 32'd1);
    check("no_cmds",   32'(n_pre), 32'd1);

    // Eight grants drain the backlog; tREFI widened so no new ticks interfere.
    cfg.trefi = 16'd5000;
    ref_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_cyc(1002 + 27 * k);
      check("drain_pre", 32'(cmd0), 32'b0010);
      wait_cyc(1007 + 27 * k);
      check("drain_ref", 32'(cmd0), 32'b0001);
      if (k == 0) begin
        wait_cyc(1008);
        check("drain_p7",  32'(dut.pending), 32'd7);
        check("drain_urg", 32'(ref_urgent), 32'd0);
      end
    end
    ref_gnt = 1'b0;
    wait_cyc(1197);
    check("drain_p0",  32'(dut.pending), 32'd0);
    check("drain_u0",  32'(ref_urgent), 32'd0);
    wait_cyc(1220);
    check("drain_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("drain_nref", 32'(n_ref), 32'd9);

    // Tick coinciding with REF issue (cycle 1307) leaves pending unchanged.
    cfg.trefi = 16'd300;
    wait_cyc(1301);
    check("coin_req",  32'(ref_req), 32'd1);
    ref_gnt = 1'b1;
    wait_cyc(1302);
    ref_gnt = 1'b0;
    cfg.trefi = 16'd7;
    wait_cyc(1307);
    check("coin_ref",  32'(cmd0), 32'b0001);
    check("coin_p_before", 32'(dut.pending), 32'd1);
    wait_cyc(1308);
    check("coin_p_after",  32'(dut.pending), 32'd1);
    cfg.trefi = 16'd5000;

    // Remaining refresh served with tRP=0: REF one cycle after PREA.
    wait_cyc(1328);
    check("trp0_req",  32'(ref_req), 32'd1);
    cfg.trp = 16'd0;
    ref_gnt = 1'b1;
    wait_cyc(1329);
    ref_gnt = 1'b0;
    check("trp0_pre",  32'(cmd0), 32'b0010);
    wait_cyc(1330);
    check("trp0_ref",  32'(cmd0), 32'b0001);
    wait_cyc(1331);
    check("trp0_p0",   32'(dut.pending), 32'd0);

    // ddr_init_done dropped during WAIT_RFC.
    wait_cyc(1335);
    check("drop_busy_pre", 32'(ref_busy), 32'd1);
    ddr_init_done = 1'b0;
    wait_cyc(1336);
    check("drop_cmd",   32'({cmd0, cmd_rest}), 32'({4'b0111, REST_NOP}));
    check("drop_busy",  32'(ref_busy), 32'd0);
    check("drop_req",   32'(ref_req), 32'd0);
    check("drop_pend",  32'(dut.pending), 32'd0);
    check("drop_cnt",   32'(dut.u_timer.cnt_q), 32'd0);
    check("drop_state", 32'(dut.state_q), 32'(ST_DISABLED));
    snap_pre = n_pre;
    snap_ref = n_ref;
    wait_cyc(1400);
    ref_gnt = 1'b1;
    wait_cyc(1401);
    ref_gnt = 1'b0;
    wait_cyc(1600);
    check("quiet_pre", 32'(n_pre), 32'(snap_pre));
    check("quiet_ref", 32'(n_ref), 32'(snap_ref));
    check("quiet_cke", 32'(dfi.cke), 32'd0);

    // Re-enable; a grant pulse with ref_req low changes nothing.
    cfg.trefi = 16'd100;
    cfg.trp   = 16'd5;
    ddr_init_done = 1'b1;
    wait_cyc(1605);
    ref_gnt = 1'b1;
    wait_cyc(1606);
    ref_gnt = 1'b0;
    check("gnt_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("gnt_busy",  32'(ref_busy), 32'd0);
    check("gnt_cmd",   32'(cmd0), 32'b0111);

    // Reset asserted mid-WAIT_RP.
    wait_cyc(1701);
    check("re_req", 32'(ref_req), 32'd1);
    ref_gnt = 1'b1;
    wait_cyc(1702);
    ref_gnt = 1'b0;
    wait_cyc(1704);
    check("mid_state", 32'(dut.state_q), 32'(ST_WAIT_RP));
    #2;
    arstn = 1'b0;
    #1;
    check("arst_req",   32'(ref_req), 32'd0);
    check("arst_urg",   32'(ref_urgent), 32'd0);
    check("arst_busy",  32'(ref_busy), 32'd0);
    check("arst_cmd",   32'({cmd0, cmd_rest}), 32'hFFFF);
    check("arst_cke",   32'(dfi.cke), 32'd0);
    check("arst_addr",  32'(dfi.address == '0 && dfi.bank == '0), 32'd1);
    check("arst_state", 32'(dut.state_q), 32'(ST_DISABLED));
    check("arst_pend",  32'(dut.pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
